// File: rtl/pr_button_pkg.sv
// Shared definitions for the Pause/Reset button conditioner:
// FSM state encoding and the board-rate default timing constants.
package pr_button_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_DB_PRESS = 2'b01,
        S_HELD     = 2'b10,
        S_DB_REL   = 2'b11
    } pr_state_t;

    // 10 ms and 2 s at a 50 MHz CLK
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_LONG_CYCLES     = 100000000;

    // Debounced level is "pressed" once a press has been accepted, until the release is.
    function automatic logic state_is_pressed(input pr_state_t s);
        return (s == S_HELD) || (s == S_DB_REL);
    endfunction

endpackage

// File: rtl/sync_nff.sv
// Generic N-flop synchroniser for asynchronous board inputs.
// RST_VAL is the value all stages load while RST is asserted.
module sync_nff #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) ff <= {SYNC_STAGES{RST_VAL}};
        else     ff <= {ff[SYNC_STAGES-2:0], d};
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/pr_button_cond.sv
// Pause/Reset pushbutton conditioner: synchronise, debounce press and
// release, emit one PR pulse per accepted press and the debounced level.
// Optional long-press CLR pulse is built when PR_LONG_PRESS_EN is defined;
// otherwise CLR is tied low and the port list is unchanged.
module pr_button_cond
    import pr_button_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int CNT_W           = 27,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic KEY,
    output logic PR,
    output logic BTN_LEVEL,
    output logic CLR
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    pr_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pr_d;
    logic             key_pressed;
    logic             pb_s;

    // Normalise to pressed-high so the synchroniser resets to "released".
    assign key_pressed = (ACTIVE_LOW != 0) ? ~KEY : KEY;

    sync_nff #(
        .SYNC_STAGES(SYNC_STAGES),
        .RST_VAL    (1'b0)
    ) u_sync (
        .CLK(CLK),
        .RST(RST),
        .d  (key_pressed),
        .q  (pb_s)
    );

    // State and debounce counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter is compared before it is incremented,
    // so it never exceeds DEBOUNCE_CYCLES-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pb_s) begin
                    state_d = S_DB_PRESS;
                    cnt_d   = '0;
                end
            end
            S_DB_PRESS: begin
                if (!pb_s) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = S_HELD;
                    pr_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HELD: begin
                if (!pb_s) begin
                    state_d = S_DB_REL;
                    cnt_d   = '0;
                end
            end
            S_DB_REL: begin
                if (pb_s) begin
                    state_d = S_HELD;
                end else if (cnt_q == DB_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered outputs, updated on the same edge as the state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PR        <= 1'b0;
            BTN_LEVEL <= 1'b0;
        end else begin
            PR        <= pr_d;
            BTN_LEVEL <= state_is_pressed(state_d);
        end
    end

`ifdef PR_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_END  = CNT_W'(LONG_CYCLES);

    logic [CNT_W-1:0] hold_q;
    logic             held_entry;

    assign held_entry = (state_q == S_DB_PRESS) && (state_d == S_HELD);

    // Hold counter: parks at LONG_CYCLES after the pulse so each press yields one CLR.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_q <= '0;
            CLR    <= 1'b0;
        end else if (held_entry) begin
            hold_q <= '0;
            CLR    <= 1'b0;
        end else if (state_is_pressed(state_q)) begin
            if (hold_q != LONG_END) hold_q <= hold_q + CNT_W'(1);
            CLR <= (hold_q == LONG_LAST);
        end else begin
            hold_q <= '0;
            CLR    <= 1'b0;
        end
    end
`else
    // Feature off: constant 0, written against LONG_CYCLES so both builds
    // reference the same parameter set.
    assign CLR = (LONG_CYCLES < 0);
`endif

endmodule

// File: tb/tb_pr_button_cond.sv
// Directed bench for pr_button_cond (SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// LONG_CYCLES=10, ACTIVE_LOW=1). Expected CLR depends on PR_LONG_PRESS_EN.
module tb_pr_button_cond;

`ifdef PR_LONG_PRESS_EN
    localparam bit LP = 1'b1;
`else
    localparam bit LP = 1'b0;
`endif

    localparam int NROWS = 85;

    typedef struct {
        logic key;
        logic pr;
        logic lvl;
        logic clr;
    } vec_t;

    logic CLK, RST, KEY;
    logic PR, BTN_LEVEL, CLR;

    int checks = 0;
    int errors = 0;

    vec_t tbl [1:NROWS];

    pr_button_cond #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (10),
        .CNT_W          (27),
        .ACTIVE_LOW     (1)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .KEY      (KEY),
        .PR       (PR),
        .BTN_LEVEL(BTN_LEVEL),
        .CLR      (CLR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0b expected %0b", name, act, exp);
        end
    endtask

    function automatic bit in_rng(input int e, input int lo, input int hi);
        return (e >= lo) && (e <= hi);
    endfunction

    initial begin
        // Table: row e drives KEY before edge e, checks outputs just after edge e.
        // Press held 1..20 (PR@7, CLR@17), bounce 21..23, release 24..33
        // (accepted @30), clean press 34..45 (PR@40), release 46..55
        // (accepted @52, CLR@50 while in release debounce), 3-cycle glitch
        // 56..58, one-short 4-cycle glitch 71..74.
        for (int e = 1; e <= NROWS; e++) begin
            tbl[e].key = !(in_rng(e, 1, 20) || e == 23 || in_rng(e, 34, 45) ||
                           in_rng(e, 56, 58) || in_rng(e, 71, 74));
            tbl[e].pr  = (e == 7) || (e == 40);
            tbl[e].lvl = in_rng(e, 7, 29) || in_rng(e, 40, 51);
            tbl[e].clr = LP && ((e == 17) || (e == 50));
        end

        // Reset state before any clock edge
        RST = 1'b1;
        KEY = 1'b1;
        #1;
        chk("reset_pr", PR, 1'b0);
        chk("reset_lvl", BTN_LEVEL, 1'b0);
        chk("reset_clr", CLR, 1'b0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        for (int e = 1; e <= NROWS; e++) begin
            @(negedge CLK);
            KEY = tbl[e].key;
            @(posedge CLK);
            #1;
            chk($sformatf("tbl_pr_e%0d", e), PR, tbl[e].pr);
            chk($sformatf("tbl_lvl_e%0d", e), BTN_LEVEL, tbl[e].lvl);
            chk($sformatf("tbl_clr_e%0d", e), CLR, tbl[e].clr);
        end

        // Asynchronous reset while the debounced level is high
        @(negedge CLK);
        KEY = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        chk("held_lvl_before_rst", BTN_LEVEL, 1'b1);
        @(negedge CLK);
        KEY = 1'b1;
        #1;
        RST = 1'b1;
        #1;
        chk("async_rst_pr", PR, 1'b0);
        chk("async_rst_lvl", BTN_LEVEL, 1'b0);
        chk("async_rst_clr", CLR, 1'b0);

        // Key held through a 3-cycle reset: one new PR 7 edges after release
        KEY = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("rstheld_pr_e%0d", e), PR, (e == 7));
            chk($sformatf("rstheld_lvl_e%0d", e), BTN_LEVEL, (e >= 7));
            chk($sformatf("rstheld_clr_e%0d", e), CLR, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pr_button_cond.md
Name: pr_button_cond

Overview:
- Conditions the raw Pause/Reset pushbutton and produces the clean single-cycle PR pulse consumed by the counter-control FSM.
- Synchronises the asynchronous key, debounces press and release, and emits exactly one PR pulse per accepted press.
- Also exports the debounced button level.
- Sits directly upstream of the run/pause/max FSM, in the CLK domain.

Parameters:
- SYNC_STAGES, 2: synchroniser flop count, minimum 2.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a press or release (10 ms at 50 MHz), minimum 2.
- LONG_CYCLES, 100000000: held cycles before the long-press CLR pulse (2 s at 50 MHz). Used only with the optional feature.
- CNT_W, 27: width of the internal counters. Must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, LONG_CYCLES).
- ACTIVE_LOW, 1: 1 means KEY low = pressed; 0 means KEY high = pressed.

Ports:
- CLK, in, 1: system clock.
- RST, in, 1: reset, asynchronous, active-high.
- KEY, in, 1: raw pushbutton, asynchronous, may bounce.
- PR, out, 1: one-CLK pulse per accepted press; registered output.
- BTN_LEVEL, out, 1: debounced pressed level, 1 = pressed; registered output.
- CLR, out, 1: long-press pulse, one CLK wide; constant 0 when the optional feature is off.

Behaviour:
- Reset (asynchronous, RST=1):
  - state = S_IDLE, all counters 0.
  - Synchroniser flops load the released value.
  - PR = 0, BTN_LEVEL = 0, CLR = 0.
- Synchroniser: KEY is normalised to pressed-high via ACTIVE_LOW, then passed through SYNC_STAGES flops. The output is pb_s. No logic reads KEY directly.
- FSM states (2-bit): S_IDLE, S_DB_PRESS, S_HELD, S_DB_REL.
- S_IDLE: if pb_s=1, go to S_DB_PRESS and set cnt=0.
- S_DB_PRESS:
  - pb_s=0: return to S_IDLE. The glitch is rejected and no output is produced.
  - pb_s=1 and cnt==DEBOUNCE_CYCLES-1: go to S_HELD.
  - Otherwise cnt++.
- S_HELD: if pb_s=0, go to S_DB_REL and set cnt=0.
- S_DB_REL:
  - pb_s=1: return to S_HELD. No new PR is issued.
  - pb_s=0 and cnt==DEBOUNCE_CYCLES-1: go to S_IDLE.
  - Otherwise cnt++.
- PR:
  - High for exactly the first cycle after the transition S_DB_PRESS to S_HELD.
  - Never high in any other cycle.
  - Never high on two consecutive cycles.
- BTN_LEVEL: 1 in S_HELD and S_DB_REL, 0 in S_IDLE and S_DB_PRESS. Registered with the state.
- Latency: KEY stable pressed before rising edge 1 gives PR high after edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
- A release is accepted only after DEBOUNCE_CYCLES stable released cycles. Repeated presses therefore need a full release in between.
- Reset mid-press: outputs clear immediately. If the key is still held after RST deasserts, it is treated as a new press and one PR follows after the normal latency.
- Counter saturation is impossible by construction because cnt is compared before increment. The CNT_W constraint guarantees no wrap.

Optional Feature:
- Macro: PR_LONG_PRESS_EN.
- Defined:
  - A hold counter clears on entry to S_HELD from S_DB_PRESS.
  - It increments in S_HELD and S_DB_REL, and is held at 0 in S_IDLE.
  - When it reaches LONG_CYCLES-1, CLR pulses high for one cycle. The counter then stops, so there is one CLR per press.
  - PR behaviour is unchanged.
- Undefined: the hold counter is not instantiated and CLR is tied to 0. The port list is identical in both builds.

Decomposition:
- Package pr_button_pkg holds:
  - the state encoding S_IDLE=2'b00, S_DB_PRESS=2'b01, S_HELD=2'b10, S_DB_REL=2'b11;
  - the default DEBOUNCE_CYCLES and LONG_CYCLES constants.
- One sub-module, sync_nff: a generic N-stage synchroniser with SYNC_STAGES and RST_VAL parameters. It is reused for the other board inputs.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, ACTIVE_LOW=1):
- RST pulsed mid-simulation with KEY=1 → PR=0, BTN_LEVEL=0, CLR=0 immediately, before any clock edge.
- KEY driven 0 before edge 1 and held → PR=1 only after edge 7, BTN_LEVEL=1 from edge 7 onward, and no further PR while held.
- KEY low for 3 cycles after synchronisation, then high → PR never asserts and BTN_LEVEL stays 0.
- In S_HELD, KEY high for 2 cycles, low again, then high for 6 or more cycles:
  - BTN_LEVEL stays 1 through the bounce and no second PR appears;
  - BTN_LEVEL goes 0 after the release is accepted;
  - a following clean press produces exactly one new PR.
- Key held, RST asserted for 3 cycles then released with KEY still 0 → exactly one PR, 7 edges after RST deasserts.
- PR_LONG_PRESS_EN defined, key held → CLR high for one cycle, 10 cycles after S_HELD entry, with only one CLR per press. Macro undefined, same stimulus → CLR stays 0 throughout.
